// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller front end: fixed button index map
// and the opposite-direction (SOCD) resolution rule.
package ctrl_pkg;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_PERY   = 5;

  localparam int SOCD_PASS    = 0;
  localparam int SOCD_NEUTRAL = 1;

  // Resolve one opposing pair {hi, lo}: in neutral mode both-held means neither.
  function automatic logic [1:0] socd_pair(input logic [1:0] pair, input int mode);
    if (mode == SOCD_NEUTRAL && pair == 2'b11) return 2'b00;
    return pair;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// One controller channel: two-flop synchroniser followed by a counter debouncer
// that accepts a new level only after it persists DEBOUNCE_CYCLES cycles.
module debounce_channel
  import ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1_p0;
  logic s2_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0  <= 1'b0;
      s2_p1  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1_p0 <= din;
      // sync -> debounce boundary
      s2_p1 <= s1_p0;
      if (s2_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/multi_controller_input.sv
// Multi-player controller front end: per-channel debounce, per-player SOCD
// resolution, then registered level, press/release pulses and long-hold flags.
module multi_controller_input
  import ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_BUTTONS     = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int SOCD_MODE       = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_held,
  output logic [NUM_BUTTONS-1:0]             led
);
  localparam int N      = NUM_PLAYERS * NUM_BUTTONS;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [N-1:0] pin_n;
  logic [N-1:0] stable_p1;
  logic [N-1:0] socd;
  logic [HOLD_W-1:0] hcnt     [N];
  logic [HOLD_W-1:0] hcnt_nxt [N];

  assign pin_n = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (pin_n[i]),
      .stable (stable_p1[i])
    );
  end

  // debounce -> output boundary
  always_comb begin
    socd = stable_p1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      socd[p*NUM_BUTTONS + BTN_LEFT +: 2] =
        socd_pair(stable_p1[p*NUM_BUTTONS + BTN_LEFT +: 2], SOCD_MODE);
      socd[p*NUM_BUTTONS + BTN_UP +: 2] =
        socd_pair(stable_p1[p*NUM_BUTTONS + BTN_UP +: 2], SOCD_MODE);
    end
  end

  // Hold count tracks cycles the registered level has already been high.
  always_comb begin
    hcnt_nxt = hcnt;
    for (int i = 0; i < N; i++) begin
      if (!btn_level[i])             hcnt_nxt[i] = '0;
      else if (hcnt[i] != HOLD_MAX)  hcnt_nxt[i] = hcnt[i] + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_held    <= '0;
      for (int i = 0; i < N; i++) hcnt[i] <= '0;
    end else begin
      btn_level   <= socd;
      btn_press   <= socd & ~btn_level;
      btn_release <= ~socd & btn_level;
      for (int i = 0; i < N; i++) begin
        hcnt[i]     <= hcnt_nxt[i];
        // Gated with socd so the flag drops in the same cycle as the level.
        btn_held[i] <= socd[i] && (hcnt_nxt[i] == HOLD_MAX);
      end
    end
  end

  assign led = btn_level[NUM_BUTTONS-1:0];
endmodule

// File: tb/tb_multi_controller_input.sv
// Bench for multi_controller_input: behavioural reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_controller_input;
  localparam int NP = 2;
  localparam int NB = 6;
  localparam int N  = NP * NB;
  localparam int D  = 4;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_held;
  logic [NB-1:0] led;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multi_controller_input #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H), .ACTIVE_LOW(1), .SOCD_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_held(btn_held), .led(led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pressed value seen two edges late, accepted after D
  // consecutive disagreeing cycles, opposing pairs cancel, level one edge later.
  logic [N-1:0] m_d1, m_d2, m_stab;
  logic [N-1:0] e_level, e_press, e_release, e_held;
  int m_mis [N];
  int m_hrun [N];

  function automatic logic [N-1:0] resolve(input logic [N-1:0] s);
    logic [N-1:0] r;
    r = s;
    for (int p = 0; p < NP; p++) begin
      if (s[p*NB+0] && s[p*NB+1]) begin r[p*NB+0] = 1'b0; r[p*NB+1] = 1'b0; end
      if (s[p*NB+2] && s[p*NB+3]) begin r[p*NB+2] = 1'b0; r[p*NB+3] = 1'b0; end
    end
    return r;
  endfunction

  wire [N-1:0] m_socd = resolve(m_stab);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 <= '0; m_d2 <= '0; m_stab <= '0;
      e_level <= '0; e_press <= '0; e_release <= '0; e_held <= '0;
      for (int i = 0; i < N; i++) begin m_mis[i] <= 0; m_hrun[i] <= 0; end
    end else begin
      m_d1 <= ~btn_raw;
      m_d2 <= m_d1;
      e_level   <= m_socd;
      e_press   <= m_socd & ~e_level;
      e_release <= ~m_socd & e_level;
      for (int i = 0; i < N; i++) begin
        if (m_d2[i] == m_stab[i]) m_mis[i] <= 0;
        else if (m_mis[i] + 1 == D) begin m_stab[i] <= ~m_stab[i]; m_mis[i] <= 0; end
        else m_mis[i] <= m_mis[i] + 1;
        if (!m_socd[i]) m_hrun[i] <= 0;
        else if (m_hrun[i] <= H) m_hrun[i] <= m_hrun[i] + 1;
        e_held[i] <= m_socd[i] && (m_hrun[i] >= H);
      end
    end
  end

  always @(negedge clk) begin
    check("level",   32'(btn_level),   32'(e_level));
    check("press",   32'(btn_press),   32'(e_press));
    check("release", 32'(btn_release), 32'(e_release));
    check("held",    32'(btn_held),    32'(e_held));
    check("led",     32'(led),         32'(e_level[NB-1:0]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Idle with buttons up; reset released between clock edges.
    #32 rst_n = 1'b1;
    repeat (10) tick();
    check("idle_level", 32'(btn_level), 32'd0);
    check("idle_press", 32'(btn_press), 32'd0);

    // P0 attack: level after 7 edges, held 8 cycles after that.
    btn_raw[4] = 1'b0;
    repeat (6) tick();
    check("atk_level_early", 32'(btn_level[4]), 32'd0);
    tick();
    check("atk_level", 32'(btn_level[4]), 32'd1);
    check("atk_press", 32'(btn_press[4]), 32'd1);
    check("atk_led",   32'(led), 32'h10);
    tick();
    check("atk_press_once", 32'(btn_press[4]), 32'd0);
    repeat (6) tick();
    check("atk_held_early", 32'(btn_held[4]), 32'd0);
    tick();
    check("atk_held", 32'(btn_held[4]), 32'd1);
    btn_raw[4] = 1'b1;
    repeat (7) tick();
    check("atk_rel_level", 32'(btn_level[4]), 32'd0);
    check("atk_release",   32'(btn_release[4]), 32'd1);
    check("atk_rel_held",  32'(btn_held[4]), 32'd0);
    repeat (3) tick();

    // P1 up: short glitch and burst rejected, 4-cycle low accepted.
    btn_raw[8] = 1'b0;
    repeat (3) tick();
    btn_raw[8] = 1'b1;
    repeat (10) tick();
    check("glitch_level", 32'(btn_level[8]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      btn_raw[8] = k[0];
      tick();
    end
    btn_raw[8] = 1'b1;
    repeat (10) tick();
    check("burst_level", 32'(btn_level[8]), 32'd0);
    btn_raw[8] = 1'b0;
    repeat (4) tick();
    btn_raw[8] = 1'b1;
    repeat (3) tick();
    check("min_level", 32'(btn_level[8]), 32'd1);
    check("min_press", 32'(btn_press[8]), 32'd1);
    repeat (10) tick();

    // SOCD: left held, right added cancels both; dropping left lets right in.
    btn_raw[0] = 1'b0;
    repeat (7) tick();
    check("left_level", 32'(btn_level[0]), 32'd1);
    btn_raw[1] = 1'b0;
    repeat (6) tick();
    check("left_still", 32'(btn_level[0]), 32'd1);
    tick();
    check("socd_left_level",   32'(btn_level[0]), 32'd0);
    check("socd_left_release", 32'(btn_release[0]), 32'd1);
    check("socd_right_level",  32'(btn_level[1]), 32'd0);
    check("socd_right_press",  32'(btn_press[1]), 32'd0);
    btn_raw[0] = 1'b1;
    repeat (7) tick();
    check("right_level",  32'(btn_level[1]), 32'd1);
    check("right_press",  32'(btn_press[1]), 32'd1);
    check("left_no_rel",  32'(btn_release[0]), 32'd0);
    btn_raw[1] = 1'b1;
    repeat (8) tick();

    // Both players: P0 left+right cancel, P1 right and down unaffected.
    btn_raw[0] = 1'b0; btn_raw[1] = 1'b0; btn_raw[7] = 1'b0; btn_raw[9] = 1'b0;
    repeat (7) tick();
    check("multi_level", 32'(btn_level), 32'h280);
    check("multi_press", 32'(btn_press), 32'h280);
    btn_raw = '1;
    repeat (8) tick();

    // Reset while P0 down is held and flagged long-held.
    btn_raw[3] = 1'b0;
    repeat (16) tick();
    check("down_held", 32'(btn_held[3]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_held",  32'(btn_held), 32'd0);
    check("rst_led",   32'(led), 32'd0);
    repeat (2) tick();
    #1 rst_n = 1'b1;
    repeat (6) tick();
    check("rerst_press_early", 32'(btn_press[3]), 32'd0);
    tick();
    check("rerst_press", 32'(btn_press[3]), 32'd1);
    check("rerst_level", 32'(btn_level[3]), 32'd1);
    btn_raw = '1;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multi_controller_input.md
Name: multi_controller_input

Overview:
- Parametrised, multi-player front end for joystick/button controllers on the Nexys A7 PMOD headers.
- Per channel, in order: synchronise raw inputs, debounce, resolve simultaneous opposite directions (SOCD), then produce level, press pulse, release pulse and long-hold flags.
- Sits between the board pins and the game-logic FSMs. Replaces per-player raw wiring; drives the debug LEDs for player 0.

Parameters:
- NUM_PLAYERS, 2, number of controllers.
- NUM_BUTTONS, 6, channels per player. Fixed index map: 0 left, 1 right, 2 up, 3 down, 4 attack, 5 pery; further indices are generic.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a new synchronised value must persist before it is accepted (10 ms at 100 MHz); must be ≥ 1.
- HOLD_CYCLES, 50000000, consecutive post-SOCD high cycles before btn_held asserts; must be ≥ 1.
- ACTIVE_LOW, 1, 1 means pins read 0 when pressed; the block inverts them before synchronising.
- SOCD_MODE, 1, 0 means pass-through; 1 means left+right both active resolves to neither, and up+down both active resolves to neither. Requires NUM_BUTTONS ≥ 4.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_PLAYERS*NUM_BUTTONS  raw pins, asynchronous to clk; channel index p*NUM_BUTTONS+b.
- btn_level  out  NUM_PLAYERS*NUM_BUTTONS  debounced, SOCD-resolved level; 1 means pressed.
- btn_press  out  NUM_PLAYERS*NUM_BUTTONS  one-cycle pulse on btn_level 0→1.
- btn_release  out  NUM_PLAYERS*NUM_BUTTONS  one-cycle pulse on btn_level 1→0.
- btn_held  out  NUM_PLAYERS*NUM_BUTTONS  high while btn_level has been high for ≥ HOLD_CYCLES cycles.
- led  out  NUM_BUTTONS  equals btn_level[NUM_BUTTONS-1:0] (player 0).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sync flops load the inactive value (0 after polarity correction), so no spurious press occurs on release.
  - Debounced state, counters, and all outputs go to 0.
- Polarity: n = ACTIVE_LOW ? ~btn_raw : btn_raw.
- Synchroniser: 2-flop chain per channel; s2 is the second stage.
- Debounce, per channel, on registers stable and cnt (width $clog2(DEBOUNCE_CYCLES+1)):
  - If s2 == stable, cnt is cleared.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable toggles and cnt is cleared.
  - Else cnt increments.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles never changes stable. Any bounce back to the stable value restarts the count from 0.
- SOCD: a combinational function of the player's stable bits, applied independently per player.
  - Only bits 0/1 and 2/3 are affected; all other bits pass through.
  - SOCD_MODE 0 passes all bits through unchanged.
- Output register: btn_level <= socd result.
  - btn_press = socd & ~btn_level, registered, so it coincides with the first cycle btn_level reads 1.
  - btn_release is symmetric.
  - Press and release are never both high on the same channel.
- Latency: a clean raw edge reaches btn_level exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it (2 sync + DEBOUNCE_CYCLES + 1 output).
- SOCD edge cases:
  - Holding left, then adding right: left level drops, producing a left release pulse. Right produces no press.
  - Releasing right afterwards: left re-presses, producing a left press pulse.
- Hold counter, per channel, saturating at HOLD_CYCLES:
  - Clears whenever btn_level is 0.
  - Increments while btn_level is 1.
  - btn_held = (hcnt == HOLD_CYCLES), registered. It deasserts in the same cycle btn_level falls.
- Reset mid-operation: all state is discarded. Buttons still pressed at rst_n rise must pass a full debounce again and then emit a fresh press pulse.
- Channels are fully independent apart from the SOCD pairs within one player.

Decomposition:
- Shared package ctrl_pkg holds:
  - button index localparams BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_ATTACK=4, BTN_PERY=5;
  - the SOCD mode constants.
- Sub-module debounce_channel (sync + debounce + stable output, parameter DEBOUNCE_CYCLES), instantiated NUM_PLAYERS*NUM_BUTTONS times in a generate loop.
- SOCD, edge detection and hold logic stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, NUM_PLAYERS=2, ACTIVE_LOW=1, SOCD_MODE=1):
- Reset then idle, btn_raw all 1 → all outputs 0 throughout. Releasing rst_n mid-cycle produces no pulses.
- P0 attack (channel 4) driven to 0 and held → btn_level[4] rises 7 edges later, btn_press[4] high for exactly that cycle, led[4]=1, btn_held[4] rises 8 cycles after level.
- P1 up (channel 8) glitch low for 3 cycles, and a separate burst 0/1/0/1 → no level change, no pulses. Holding it low for 4 cycles → accepted.
- P0 left pressed, then right added → left release pulse on the cycle right's debounce completes. Both levels read 0, no right press. Releasing left → right press pulse.
- Both players pressing different buttons simultaneously → independent correct levels; P1 SOCD unaffected by P0.
- rst_n asserted while P0 down is held with btn_held=1 → all outputs 0 immediately. After release, btn_press[3] occurs 7 edges later.
